// File: rtl/usr_pkg.sv
// Shared opcode and FSM state definitions for the universal shift sequencer family.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROL   = 3'b100,
    OP_ROR   = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Multi-cycle ops are the ones that consume a shift amount.
  function automatic logic is_step_op(input op_t op);
    logic r;
    case (op)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-bit step of the universal shifter; reusable for any width N.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] q,
  input  op_t          op,
  input  logic         sin_l,
  input  logic         sin_r,
  output logic [N-1:0] next_q,
  output logic         out_bit
);

  // One step of the selected shift/rotate; non-shift ops pass q through.
  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        next_q  = {q[N-2:0], sin_r};
        out_bit = q[N-1];
      end
      OP_SHR: begin
        next_q  = {sin_l, q[N-1:1]};
        out_bit = q[0];
      end
      OP_ROL: begin
        next_q  = {q[N-2:0], q[N-1]};
        out_bit = q[N-1];
      end
      OP_ROR: begin
        next_q  = {q[0], q[N-1:1]};
        out_bit = q[0];
      end
      OP_ASR: begin
        next_q  = {q[N-1], q[N-1:1]};
        out_bit = q[0];
      end
      default: begin
        next_q  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_seq.sv
// Sequenced universal shift register: one op per start, multi-cycle shift-by-amount,
// start/busy/done handshake with registered outputs.
module univ_shift_seq
  import usr_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amt,
  input  logic [N-1:0]     d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [N-1:0]     q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  op_t              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     q_q;
  logic             sout_q;
  logic             busy_q;
  logic             done_q;

  logic [N-1:0]     step_q_d;
  logic             step_out_d;
  op_t              op_in_s;

  assign op_in_s = op_t'(op);

  usr_shift_step #(.N(N)) u_step (
    .q       (q_q),
    .op      (op_q),
    .sin_l   (sin_l),
    .sin_r   (sin_r),
    .next_q  (step_q_d),
    .out_bit (step_out_d)
  );

  // Control FSM, down-counter and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= CNT_ZERO;
      q_q     <= {N{1'b0}};
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q <= op_in_s;
            case (op_in_s)
              OP_LOAD: begin
                q_q     <= d;
                state_q <= ST_DONE;
              end
              OP_CLEAR: begin
                q_q     <= {N{1'b0}};
                state_q <= ST_DONE;
              end
              OP_NOP: begin
                state_q <= ST_DONE;
              end
              default: begin
                if (is_step_op(op_in_s) && (amt != CNT_ZERO)) begin
                  cnt_q   <= amt;
                  busy_q  <= 1'b1;
                  state_q <= ST_SHIFT;
                end else begin
                  state_q <= ST_DONE;
                end
              end
            endcase
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          q_q    <= step_q_d;
          sout_q <= step_out_d;
          cnt_q  <= cnt_q - CNT_ONE;
          // The step taken with one count left is the last one.
          if (cnt_q == CNT_ONE) begin
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          cnt_q   <= CNT_ZERO;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_seq.sv
// Self-checking bench for univ_shift_seq: N=4 table + random model checks, N=8 scaling case.
module tb_univ_shift_seq;
  import usr_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       start4 = 1'b0;
  logic [2:0] op4 = 3'b000;
  logic [2:0] amt4 = 3'b000;
  logic [3:0] d4 = 4'b0000;
  logic       sr4 = 1'b0, sl4 = 1'b0;
  logic [3:0] q4;
  logic       sout4, busy4, done4;

  logic       start8 = 1'b0;
  logic [2:0] op8 = 3'b000;
  logic [3:0] amt8 = 4'b0000;
  logic [7:0] d8 = 8'h00;
  logic       sr8 = 1'b0, sl8 = 1'b0;
  logic [7:0] q8;
  logic       sout8, busy8, done8;

  int n_vec = 0;
  int n_err = 0;

  univ_shift_seq #(.N(4), .CNT_W(3)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .op(op4), .amt(amt4), .d(d4),
    .sin_r(sr4), .sin_l(sl4), .q(q4), .sout(sout4), .busy(busy4), .done(done4)
  );

  univ_shift_seq #(.N(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .amt(amt8), .d(d8),
    .sin_r(sr8), .sin_l(sl8), .q(q8), .sout(sout8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference result of applying op k times, from plain arithmetic on a 4-bit value.
  function automatic logic [3:0] ref_q(input logic [3:0] qv, input logic [2:0] o, input int k,
                                       input bit sr, input bit sl, input logic [3:0] dv);
    logic [3:0] t, m;
    logic [7:0] dbl;
    logic signed [3:0] s;
    dbl = {qv, qv};
    case (o)
      3'b000: return qv;
      3'b001: return dv;
      3'b111: return 4'b0000;
      3'b010: begin
        if (k >= 4) return {4{sr}};
        t = qv << k;
        m = 4'(((1 << k) - 1));
        return sr ? (t | m) : t;
      end
      3'b011: begin
        if (k >= 4) return {4{sl}};
        t = qv >> k;
        m = 4'b1111 >> k;
        return sl ? (t | ~m) : t;
      end
      3'b100: begin dbl = dbl << (k % 4); return dbl[7:4]; end
      3'b101: begin dbl = dbl >> (k % 4); return dbl[3:0]; end
      default: begin
        s = qv;
        s = s >>> ((k > 3) ? 3 : k);
        return s;
      end
    endcase
  endfunction

  // Issue one op on the N=4 instance; optionally raise an extra (to-be-ignored) LOAD at cycle poke.
  task automatic run_op(input logic [2:0] o, input logic [2:0] a, input logic [3:0] dv,
                        input bit sr, input bit sl, input int poke,
                        input logic [3:0] eq, input bit es, input string nm);
    int k, busy_n, done_n, done_at;
    k = (o == 3'b000 || o == 3'b001 || o == 3'b111) ? 0 : int'(a);
    @(negedge clk);
    start4 = 1'b1; op4 = o; amt4 = a; d4 = dv; sr4 = sr; sl4 = sl;
    @(posedge clk);
    busy_n = 0; done_n = 0; done_at = -1;
    for (int c = 0; c <= k + 3; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      if (busy4) busy_n++;
      if (done4) begin done_n++; done_at = c; end
      if (busy4 && done4) chk({nm, " busy&done"}, 32'd1, 32'd0);
      start4 = (c == poke);
      if (c == poke) begin op4 = 3'b001; d4 = 4'b1111; end
    end
    chk({nm, " q"}, q4, eq);
    chk({nm, " sout"}, sout4, es);
    chk({nm, " busy cycles"}, busy_n, k);
    chk({nm, " done pulses"}, done_n, 1);
    chk({nm, " done cycle"}, done_at, k + 1);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [2:0] amt;
    logic [3:0] d;
    bit         sr;
    bit         sl;
    logic [3:0] eq;
    bit         es;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [3:0] q_m, eq, prev, dv;
    logic [2:0] o, a;
    bit s_m, es, sr, sl;
    int busy_n, done_n;

    tbl[0]  = '{OP_LOAD,  3'd0, 4'b1010, 1'b0, 1'b0, 4'b1010, 1'b0};
    tbl[1]  = '{OP_SHL,   3'd2, 4'b0000, 1'b1, 1'b0, 4'b1011, 1'b0};
    tbl[2]  = '{OP_LOAD,  3'd0, 4'b1010, 1'b0, 1'b0, 4'b1010, 1'b0};
    tbl[3]  = '{OP_ROL,   3'd4, 4'b0000, 1'b0, 1'b0, 4'b1010, 1'b0};
    tbl[4]  = '{OP_ASR,   3'd1, 4'b0000, 1'b0, 1'b0, 4'b1101, 1'b0};
    tbl[5]  = '{OP_ROR,   3'd6, 4'b0000, 1'b0, 1'b0, 4'b0111, 1'b0};
    tbl[6]  = '{OP_CLEAR, 3'd0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[7]  = '{OP_SHR,   3'd7, 4'b0000, 1'b0, 1'b1, 4'b1111, 1'b1};
    tbl[8]  = '{OP_NOP,   3'd3, 4'b0101, 1'b0, 1'b0, 4'b1111, 1'b1};
    tbl[9]  = '{OP_LOAD,  3'd5, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1};
    tbl[10] = '{OP_ASR,   3'd7, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[11] = '{OP_LOAD,  3'd0, 4'b1001, 1'b0, 1'b0, 4'b1001, 1'b0};
    tbl[12] = '{OP_ROR,   3'd0, 4'b0000, 1'b0, 1'b0, 4'b1001, 1'b0};
    tbl[13] = '{OP_ROL,   3'd3, 4'b0000, 1'b0, 1'b0, 4'b1100, 1'b0};
    tbl[14] = '{OP_SHL,   3'd1, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1};

    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset q4", q4, 4'b0000);
    chk("reset busy4", busy4, 1'b0);
    chk("reset done4", done4, 1'b0);
    chk("reset sout4", sout4, 1'b0);
    chk("reset q8", q8, 8'h00);

    for (int i = 0; i < 15; i++)
      run_op(tbl[i].op, tbl[i].amt, tbl[i].d, tbl[i].sr, tbl[i].sl, -1,
             tbl[i].eq, tbl[i].es, $sformatf("tbl%0d", i));

    // A LOAD presented while shifting, and another while in DONE, must both be dropped.
    run_op(OP_LOAD, 3'd0, 4'b1010, 1'b0, 1'b0, -1, 4'b1010, 1'b1, "reload");
    run_op(OP_SHR, 3'd3, 4'b0000, 1'b0, 1'b0, 1, 4'b0001, 1'b0, "shr busy-poke");
    run_op(OP_SHR, 3'd0, 4'b0000, 1'b0, 1'b0, 0, 4'b0001, 1'b0, "shr0 done-poke");

    q_m = 4'b0001;
    s_m = 1'b0;
    for (int i = 0; i < 40; i++) begin
      o  = 3'($urandom_range(0, 7));
      a  = 3'($urandom_range(0, 7));
      dv = 4'($urandom_range(0, 15));
      sr = 1'($urandom_range(0, 1));
      sl = 1'($urandom_range(0, 1));
      eq = ref_q(q_m, o, int'(a), sr, sl, dv);
      es = s_m;
      if (!(o == 3'b000 || o == 3'b001 || o == 3'b111) && a != 3'd0) begin
        prev = ref_q(q_m, o, int'(a) - 1, sr, sl, dv);
        es = (o == 3'b010 || o == 3'b100) ? prev[3] : prev[0];
      end
      run_op(o, a, dv, sr, sl, -1, eq, es, $sformatf("rnd%0d", i));
      q_m = eq;
      s_m = es;
    end

    // Asynchronous reset in the middle of a shift.
    run_op(OP_LOAD, 3'd0, 4'b1010, 1'b0, 1'b0, -1, 4'b1010, s_m, "pre-reset load");
    @(negedge clk);
    start4 = 1'b1; op4 = OP_SHL; amt4 = 3'd3; sr4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset step1 q", q4, 4'b0100);
    chk("midreset step1 sout", sout4, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("midreset q", q4, 4'b0000);
    chk("midreset busy", busy4, 1'b0);
    chk("midreset sout", sout4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    done_n = 0;
    busy_n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done4) done_n++;
      if (busy4) busy_n++;
    end
    chk("midreset no done", done_n, 0);
    chk("midreset no busy", busy_n, 0);
    chk("midreset q after", q4, 4'b0000);

    // Width scaling: N=8, shift right by more than N with ones filling.
    @(negedge clk);
    start8 = 1'b1; op8 = OP_LOAD; d8 = 8'h81;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("n8 load q", q8, 8'h81);
    @(negedge clk);
    start8 = 1'b1; op8 = OP_SHR; amt8 = 4'd9; sl8 = 1'b1;
    @(posedge clk);
    busy_n = 0;
    done_n = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (busy8) busy_n++;
      if (done8) done_n++;
    end
    chk("n8 shr9 q", q8, 8'hFF);
    chk("n8 shr9 sout", sout8, 1'b1);
    chk("n8 shr9 busy cycles", busy_n, 9);
    chk("n8 shr9 done pulses", done_n, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
